// File: rtl/seven_seg_feed.sv
// seven_seg_feed: upstream feeder for the two-digit multiplexed seven-segment
// display driver. Converts a 7-bit binary value (0..99) into packed BCD with a
// sequential shift-add-3 engine behind a load/busy/done handshake, holds the
// displayed digits and decimal points between updates, and generates the slow
// digit-select scan square wave.
//
// Optional feature macro: SEVEN_SEG_FEED_BLINK_EN
//   When defined, an 8-bit blink counter advances on every scan toggle and the
//   decimal points blink with its MSB while an overflow is being displayed.
//   When undefined, dp always reflects the captured dp_in.

module seven_seg_feed #(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] bin,
    input  logic [1:0] dp_in,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic [7:0] d,
    output logic [1:0] dp,
    output logic       scan
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(SCAN_DIV - 1);

    state_t     state;
    state_t     state_nxt;

    // conversion scratch
    logic [6:0] bin_sh;
    logic [7:0] bcd;
    logic [7:0] bcd_adj;
    logic [2:0] iter_cnt;
    logic [1:0] dp_cap;
    logic       ovf_cap;

    // values shown between updates
    logic [7:0] d_hold;
    logic [1:0] dp_hold;
    logic       ovf_hold;

    // value published during the DONE cycle
    logic [7:0] d_new;
    logic       ovf_int;
    logic [1:0] dp_base;

    // scan prescaler
    logic [DIV_W-1:0] pre_cnt;
    logic             scan_tick;

    assign scan_tick = (pre_cnt == PRE_LAST);

    // add-3 correction of each BCD nibble before the next shift
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) begin
            bcd_adj[3:0] = bcd[3:0] + 4'd3;
        end
        if (bcd[7:4] >= 4'd5) begin
            bcd_adj[7:4] = bcd[7:4] + 4'd3;
        end
    end

    // out-of-range requests skip the engine and show the error pattern
    assign d_new = ovf_cap ? 8'hEE : bcd;

    // state register; reset abandons any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; loads are only looked at while idle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = (bin > 7'd99) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (iter_cnt == 3'd6) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // handshake outputs and the displayed values, fresh only in the DONE cycle
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        d       = d_hold;
        ovf_int = ovf_hold;
        dp_base = dp_hold;
        if (state == DONE) begin
            d       = d_new;
            ovf_int = ovf_cap;
            dp_base = dp_cap;
        end
    end

    assign ovf = ovf_int;

    // capture the request and run one shift-add-3 iteration per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sh   <= 7'd0;
            bcd      <= 8'd0;
            iter_cnt <= 3'd0;
            dp_cap   <= 2'b00;
            ovf_cap  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sh   <= bin;
                        bcd      <= 8'd0;
                        iter_cnt <= 3'd0;
                        dp_cap   <= dp_in;
                        ovf_cap  <= (bin > 7'd99);
                    end
                end
                SHIFT: begin
                    bcd      <= {bcd_adj[6:0], bin_sh[6]};
                    bin_sh   <= {bin_sh[5:0], 1'b0};
                    iter_cnt <= iter_cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // latch the published result so it stays steady until the next DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_hold   <= 8'h00;
            dp_hold  <= 2'b00;
            ovf_hold <= 1'b0;
        end else if (state == DONE) begin
            d_hold   <= d_new;
            dp_hold  <= dp_cap;
            ovf_hold <= ovf_cap;
        end
    end

    // free-running prescaler toggling scan at each terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            scan    <= 1'b0;
        end else if (scan_tick) begin
            pre_cnt <= '0;
            scan    <= ~scan;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

`ifdef SEVEN_SEG_FEED_BLINK_EN
    logic [7:0] blink_cnt;

    // blink phase restarts on each new overflow and advances with scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= 8'd0;
        end else if ((state == DONE) && ovf_cap) begin
            blink_cnt <= 8'd0;
        end else if (scan_tick) begin
            blink_cnt <= blink_cnt + 8'd1;
        end
    end

    assign dp = ovf_int ? {2{blink_cnt[7]}} : dp_base;
`else
    assign dp = dp_base;
`endif

endmodule

// File: doc/seven_seg_feed.md
Name: seven_seg_feed

Overview:
- Upstream feeder for the two-digit multiplexed seven-segment display driver.
- Converts a 7-bit binary value (0..99) into two packed BCD digits with a sequential shift-add-3 (double dabble) engine and a load/busy/done handshake.
- Holds the displayed digit pair and decimal points stable between updates.
- Generates the slow digit-select scan signal that the display driver uses to alternate between digits.

Parameters:
- SCAN_DIV, 50000, clk cycles per scan half-period; must be >= 1.
- DIV_W, 16, prescaler counter width; must hold SCAN_DIV-1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- bin, input, 7: binary value to display, valid 0..99.
- dp_in, input, 2: decimal points, captured together with bin.
- load, input, 1: start request; sampled only while busy=0.
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse when d/dp are updated.
- ovf, output, 1: last accepted bin was >99.
- d, output, 8: BCD digits; [7:4] = tens, [3:0] = ones.
- dp, output, 2: decimal points to the display driver.
- scan, output, 1: digit-select square wave to the display driver.

Behaviour:
- Reset (async, rst_n=0): d=8'h00, dp=2'b00, busy=0, done=0, ovf=0, scan=0, prescaler=0, state=IDLE. Takes effect immediately, including mid-conversion; a partial result is discarded and no done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 at edge 0 captures bin and dp_in.
  - If bin<=99: clear BCD scratch, iteration count=0, go to SHIFT.
  - If bin>99: go to DONE directly.
- SHIFT, one iteration per clk, 7 iterations:
  - Each BCD nibble >=5 gets +3.
  - Then {bcd,bin_sh} shifts left by 1.
  - After iteration 7, go to DONE.
  - Scratch is 8 bits; the tens nibble never exceeds 9 for inputs <=99.
- DONE, one cycle, then back to IDLE:
  - In-range input: d=scratch, dp=captured dp_in, ovf=0, done=1.
  - bin>99: d=8'hEE, ovf=1, dp=captured dp_in, done=1.
- Latency: in-range load at edge 0 gives done/d valid at edge 8. Overflow load at edge 0 gives done/d valid at edge 1.
- busy=1 from the edge after load is accepted through the done cycle inclusive. It is 0 in IDLE.
- load while busy=1 is ignored (not queued), including load coincident with done. A new load is accepted the cycle after done.
- d, dp and ovf change only in DONE; they are held (no flicker) during conversion.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 continuously, independent of the FSM.
  - At terminal count it wraps to 0 and scan toggles.
  - scan period = 2*SCAN_DIV clk cycles.
  - SCAN_DIV=1 toggles scan every clk.

Optional Feature:
- Macro: SEVEN_SEG_FEED_BLINK_EN.
- Defined:
  - An 8-bit blink counter increments on each scan toggle.
  - While ovf=1, dp = {2{blink_cnt[7]}}, overriding the captured dp_in.
  - The blink counter resets to 0 on rst_n.
  - The blink counter clears whenever a DONE cycle sets ovf=1.
- Undefined:
  - No blink counter.
  - dp is always the captured dp_in.
  - ovf is reported only on the ovf port.

Test Plan:
- Release reset, bin=42, dp_in=2'b01, load for 1 cycle -> busy=1 for edges 1..8, done pulse at edge 8, d=8'h42, dp=2'b01, ovf=0.
- bin=99 -> d=8'h99 at edge 8; then bin=0 -> d=8'h00; then bin=10 -> d=8'h10.
- bin=100 -> done at edge 1, d=8'hEE, ovf=1; then bin=5 -> d=8'h05, ovf=0. With the macro defined and SCAN_DIV=1, dp toggles every 128 scan toggles while ovf=1.
- Load bin=63, then assert load with bin=17 at edge 3 and again coincident with done -> d=8'h63, no second done; a load the next cycle is accepted.
- SCAN_DIV=4 -> scan toggles every 4 clk (period 8), unaffected by concurrent conversions.
- rst_n low at edge 4 of a conversion of bin=77 -> all outputs 0 immediately, no done after release, d stays 8'h00 until a new load.
